// File: rtl/servo_step_sequencer.sv
// ---------------------------------------------------------------------------
// servo_step_sequencer
//
// Generates a fixed-period servo PWM frame and steps the pulse width through
// NUM_STEPS evenly spaced levels, holding each level for DWELL_FRAMES frames.
// The run-time mode selects hold, wrap-around loop, ping-pong or one-shot.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (synchronous release)
//   en         in   1 = sequencer advances, 0 = step and dwell frozen
//   mode       in   00 hold, 01 loop, 10 ping-pong, 11 one-shot
//   pwm        out  servo control pulse (registered)
//   step       out  current step index
//   frame_tick out  one-cycle pulse on the last cycle of every frame
//   done       out  one-shot sequence finished
//   led        out  toggles on every advance that changes step
//
// Optional feature macro: STOP_PULSE_EN
//   Defined:   while en=0, pwm is held low from the next frame boundary and
//              resumes with the stored width at the first boundary after en=1.
//   Undefined: pwm keeps pulsing the current width while en=0.
// ---------------------------------------------------------------------------
module servo_step_sequencer #(
  parameter int unsigned FRAME_CYC    = 1000000,
  parameter int unsigned MIN_CYC      = 50000,
  parameter int unsigned MAX_CYC      = 100000,
  parameter int unsigned NUM_STEPS    = 5,
  parameter int unsigned STEP_W       = 3,
  parameter int unsigned DWELL_FRAMES = 150
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic              pwm,
  output logic [STEP_W-1:0] step,
  output logic              frame_tick,
  output logic              done,
  output logic              led
);

  localparam int unsigned CNT_W   = $clog2(FRAME_CYC + 1);
  localparam int unsigned DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   FRAME_LAST = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0]   FRAME_PRE  = CNT_W'(FRAME_CYC - 2);
  localparam logic [CNT_W-1:0]   WIDTH_MIN  = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0]   STEP_INC   = CNT_W'((MAX_CYC - MIN_CYC) / (NUM_STEPS - 1));
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_LOOP     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   width_q, width_d;
  dir_e               dir_q, dir_d;
  logic               pwm_q, pwm_d;
  logic               frame_tick_q;
  logic               done_q, done_d;
  logic               led_q, led_d;
  logic               advance;
  logic               step_chg;
  logic               go_up;

`ifdef STOP_PULSE_EN
  logic hold_off_q;

  // Latched only at the frame boundary so a pulse is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_off_q <= 1'b0;
    end else if (frame_tick_q) begin
      hold_off_q <= ~en;
    end
  end
`endif

  always_comb begin
    frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + CNT_W'(1);
`ifdef STOP_PULSE_EN
    pwm_d = (frame_cnt_q < width_q) && !hold_off_q;
`else
    pwm_d = (frame_cnt_q < width_q);
`endif
  end

  // Ping-pong direction is taken from the stored dir, but an endpoint always
  // forces the legal direction so a mode switch can never under/overflow.
  assign go_up = (step_q == '0) || ((dir_q == DIR_UP) && (step_q != STEP_LAST));

  always_comb begin
    dwell_cnt_d = dwell_cnt_q;
    step_d      = step_q;
    width_d     = width_q;
    dir_d       = dir_q;
    done_d      = done_q;
    led_d       = led_q;
    advance     = 1'b0;
    step_chg    = 1'b0;

    if (mode_s != MODE_ONESHOT) begin
      done_d = 1'b0;
    end

    if (frame_tick_q && en) begin
      if (dwell_cnt_q == DWELL_LAST) begin
        dwell_cnt_d = '0;
        advance     = 1'b1;
      end else begin
        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
      end
    end

    if (advance) begin
      unique case (mode_s)
        MODE_HOLD: begin
          step_chg = 1'b0;
        end
        MODE_LOOP: begin
          step_chg = 1'b1;
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            width_d = WIDTH_MIN;
          end else begin
            step_d  = step_q + STEP_W'(1);
            width_d = width_q + STEP_INC;
          end
        end
        MODE_PINGPONG: begin
          step_chg = 1'b1;
          if (go_up) begin
            step_d  = step_q + STEP_W'(1);
            width_d = width_q + STEP_INC;
            dir_d   = (step_q + STEP_W'(1) == STEP_LAST) ? DIR_DOWN : DIR_UP;
          end else begin
            step_d  = step_q - STEP_W'(1);
            width_d = width_q - STEP_INC;
            dir_d   = (step_q == STEP_W'(1)) ? DIR_UP : DIR_DOWN;
          end
        end
        MODE_ONESHOT: begin
          if (done_q) begin
            step_chg = 1'b0;
          end else if (step_q == STEP_LAST) begin
            // Entering one-shot with the last step already reached (e.g.
            // after leaving a finished run) restarts the sequence.
            step_chg = 1'b1;
            step_d   = '0;
            width_d  = WIDTH_MIN;
            dir_d    = DIR_UP;
          end else begin
            step_chg = 1'b1;
            step_d   = step_q + STEP_W'(1);
            width_d  = width_q + STEP_INC;
            if (step_q + STEP_W'(1) == STEP_LAST) begin
              done_d = 1'b1;
            end
          end
        end
        default: begin
          step_chg = 1'b0;
        end
      endcase

      if (step_chg) begin
        led_d = ~led_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      dwell_cnt_q  <= '0;
      step_q       <= '0;
      width_q      <= WIDTH_MIN;
      dir_q        <= DIR_UP;
      pwm_q        <= 1'b0;
      frame_tick_q <= 1'b0;
      done_q       <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      // Registered one cycle early so it lines up with frame_cnt == FRAME_CYC-1.
      frame_tick_q <= (frame_cnt_q == FRAME_PRE);
      pwm_q        <= pwm_d;
      dwell_cnt_q  <= dwell_cnt_d;
      step_q       <= step_d;
      width_q      <= width_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      led_q        <= led_d;
    end
  end

  assign pwm        = pwm_q;
  assign step       = step_q;
  assign frame_tick = frame_tick_q;
  assign led        = led_q;
  // Gated by mode so leaving one-shot clears done in the same cycle.
  assign done       = done_q && (mode_s == MODE_ONESHOT);

endmodule

// File: tb/tb_servo_step_sequencer.sv
module tb_servo_step_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [1:0] mode  = 2'b00;
  logic       pwm;
  logic [2:0] step;
  logic       frame_tick;
  logic       done;
  logic       led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  servo_step_sequencer #(
    .FRAME_CYC   (100),
    .MIN_CYC     (10),
    .MAX_CYC     (30),
    .NUM_STEPS   (5),
    .STEP_W      (3),
    .DWELL_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .pwm       (pwm),
    .step      (step),
    .frame_tick(frame_tick),
    .done      (done),
    .led       (led)
  );

  typedef struct {
    bit         rst;
    bit         en;
    logic [1:0] mode;
    int         nfr;
    int         stp;
    int         wid;
    int         led;
    int         done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic add(input bit r, input bit e, input logic [1:0] m, input int n,
                     input int s, input int w, input int l, input int d);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.nfr = n;
    v.stp = s; v.wid = w; v.led = l; v.done = d;
    vecs.push_back(v);
  endtask

  // Reset is released on a falling edge; the next 100 falling-edge samples
  // then form one complete frame window.
  task automatic do_reset(input logic e, input logic [1:0] m);
    @(negedge clk);
    en    = e;
    mode  = m;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_frame(input int s, input int w, input int l, input int d,
                             input string tag);
    int hi   = 0;
    int pbad = 0;
    int tbad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk({tag, ".step"}, int'(step), s);
        chk({tag, ".led"},  int'(led),  l);
        chk({tag, ".done"}, int'(done), d);
      end
      if (pwm === 1'b1) hi++;
      if (pwm !== (i < w)) pbad++;
      if (frame_tick !== (i == 98)) tbad++;
    end
    chk({tag, ".pwm_width"}, hi, w);
    chk({tag, ".pwm_shape_errs"}, pbad, 0);
    chk({tag, ".tick_errs"}, tbad, 0);
  endtask

  initial begin
    // loop mode from reset
    add(1, 1, 2'b01, 2, 0, 10, 0, 0);
    add(0, 1, 2'b01, 2, 1, 15, 1, 0);
    add(0, 1, 2'b01, 2, 2, 20, 0, 0);
    add(0, 1, 2'b01, 2, 3, 25, 1, 0);
    add(0, 1, 2'b01, 2, 4, 30, 0, 0);
    add(0, 1, 2'b01, 2, 0, 10, 1, 0);
    add(0, 1, 2'b01, 1, 1, 15, 0, 0);
    // ping-pong, endpoints held one dwell each
    add(1, 1, 2'b10, 2, 0, 10, 0, 0);
    add(0, 1, 2'b10, 2, 1, 15, 1, 0);
    add(0, 1, 2'b10, 2, 2, 20, 0, 0);
    add(0, 1, 2'b10, 2, 3, 25, 1, 0);
    add(0, 1, 2'b10, 2, 4, 30, 0, 0);
    add(0, 1, 2'b10, 2, 3, 25, 1, 0);
    add(0, 1, 2'b10, 2, 2, 20, 0, 0);
    add(0, 1, 2'b10, 2, 1, 15, 1, 0);
    add(0, 1, 2'b10, 2, 0, 10, 0, 0);
    add(0, 1, 2'b10, 2, 1, 15, 1, 0);
    // one-shot, then switch to loop
    add(1, 1, 2'b11, 2, 0, 10, 0, 0);
    add(0, 1, 2'b11, 2, 1, 15, 1, 0);
    add(0, 1, 2'b11, 2, 2, 20, 0, 0);
    add(0, 1, 2'b11, 2, 3, 25, 1, 0);
    add(0, 1, 2'b11, 4, 4, 30, 0, 1);
    add(0, 1, 2'b01, 2, 4, 30, 0, 0);
    add(0, 1, 2'b01, 1, 0, 10, 1, 0);
    // en freeze at step 2, resume, then hold mode
    add(1, 1, 2'b01, 2, 0, 10, 0, 0);
    add(0, 1, 2'b01, 2, 1, 15, 1, 0);
    add(0, 0, 2'b01, 10, 2, 20, 0, 0);
    add(0, 1, 2'b01, 2, 2, 20, 0, 0);
    add(0, 1, 2'b00, 6, 3, 25, 1, 0);

    repeat (3) @(negedge clk);
    chk("reset.pwm",        int'(pwm),        0);
    chk("reset.frame_tick", int'(frame_tick), 0);
    chk("reset.step",       int'(step),       0);
    chk("reset.done",       int'(done),       0);
    chk("reset.led",        int'(led),        0);

    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].rst) begin
        do_reset(vecs[r].en, vecs[r].mode);
      end else begin
        en   = vecs[r].en;
        mode = vecs[r].mode;
      end
      for (int f = 0; f < vecs[r].nfr; f++) begin
        check_frame(vecs[r].stp, vecs[r].wid, vecs[r].led, vecs[r].done,
                    $sformatf("row%0d.f%0d", r, f));
      end
    end

    // done clears in the same cycle the mode leaves one-shot; re-entry restarts
    do_reset(1'b1, 2'b11);
    repeat (800) @(negedge clk);
    chk("oneshot.end_step", int'(step), 4);
    chk("oneshot.end_done", int'(done), 1);
    mode = 2'b01;
    #1;
    chk("oneshot.done_same_cycle", int'(done), 0);
    @(negedge clk);
    mode = 2'b11;
    #1;
    chk("oneshot.done_after_reentry", int'(done), 0);
    repeat (199) @(negedge clk);
    chk("oneshot.restart_step", int'(step), 0);
    check_frame(0, 10, 1, 0, "oneshot.restart");

    // asynchronous reset in the middle of a 20-cycle pulse
    do_reset(1'b1, 2'b01);
    repeat (415) @(negedge clk);
    chk("midrst.step_before", int'(step), 2);
    chk("midrst.pwm_before",  int'(pwm),  1);
    rst_n = 1'b0;
    #1;
    chk("midrst.pwm_async",  int'(pwm),  0);
    chk("midrst.step_async", int'(step), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(0, 10, 0, 0, "midrst.first");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_step_sequencer.md
Name: servo_step_sequencer

Overview:
Parametrised servo speed/position sequencer. It generates a fixed-period servo PWM frame internally and steps the pulse width through NUM_STEPS evenly spaced levels. Each level is held for a programmable number of frames. Stepping follows a run-time mode: hold, wrap-around loop, ping-pong or one-shot. It replaces the fixed divider + 5-level selector + pulse generator chain in the motor test tops, and drives the servo pin and a status LED directly.

Parameters:
FRAME_CYC, 1000000, clk cycles per PWM frame (20 ms at 50 MHz)
MIN_CYC, 50000, pulse width at step 0 in clk cycles (1 ms)
MAX_CYC, 100000, nominal pulse width at step NUM_STEPS-1 (2 ms)
NUM_STEPS, 5, number of levels; legal range 2..2**STEP_W
STEP_W, 3, width of step index
DWELL_FRAMES, 150, frames per step (3 s at 50 Hz); must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = sequencer advances; 0 = step and dwell frozen
mode  in  2  00 hold, 01 loop, 10 ping-pong, 11 one-shot
pwm  out  1  servo control pulse
step  out  STEP_W  current step index
frame_tick  out  1  one-cycle pulse on the last cycle of every frame
done  out  1  one-shot sequence finished
led  out  1  toggles on every step advance

Behaviour:
- Reset (async assert, sync release): frame_cnt=0, dwell_cnt=0, step=0, width=MIN_CYC, dir=up, pwm=0, frame_tick=0, done=0, led=0.
- Step increment: STEP_INC = floor((MAX_CYC-MIN_CYC)/(NUM_STEPS-1)), elaboration constant. Width of step k = MIN_CYC + k*STEP_INC.
  - width is maintained incrementally (+/-STEP_INC per advance). No runtime multiply or divide.
- frame_cnt counts 0..FRAME_CYC-1 and wraps. It free-runs regardless of en and mode.
- pwm is registered, 1-cycle latency: pwm <= (frame_cnt < width).
  - High exactly width cycles per frame, starting on the cycle after frame_cnt=0.
- frame_tick is high for the cycle where frame_cnt == FRAME_CYC-1.
- width and step change only on frame_tick cycles. No mid-frame glitch or truncated pulse is allowed.
- Dwell: on frame_tick with en=1, dwell_cnt increments. When dwell_cnt == DWELL_FRAMES-1, dwell_cnt <= 0 and an advance event fires. With en=0, dwell_cnt holds.
- Advance event, per mode sampled at that cycle:
  - 00 hold: step unchanged, led does not toggle.
  - 01 loop: step+1; from NUM_STEPS-1 wraps to 0 and width reloads MIN_CYC.
  - 10 ping-pong: dir up: step+1; on reaching NUM_STEPS-1, dir <= down. dir down: step-1; on reaching 0, dir <= up. Endpoints are held for exactly one dwell (no double dwell).
  - 11 one-shot: step+1 until NUM_STEPS-1, then done <= 1 and step holds.
- led toggles on every advance event that changes step.
- done is cleared, in the same cycle, when mode != 11. Re-entering one-shot from done restarts at the next advance: step 0, width MIN_CYC.
- Mode change mid-dwell does not reset dwell_cnt. The new mode applies at the next advance. Switching from down-moving ping-pong to loop continues upward from the current step.
- en deassert mid-frame: the current frame and pulse complete normally, and pwm keeps repeating the current width.
- Reset mid-frame: pwm drops immediately (async).

Optional Feature:
- Macro STOP_PULSE_EN.
- Defined: while en=0, pwm is forced 0 starting at the next frame boundary (servo released, no holding torque). On en re-assert, pulses resume at the next frame boundary with the stored width.
- Undefined: pwm keeps pulsing the current width while en=0.

Test Plan:
Sim parameters for all scenarios: FRAME_CYC=100, MIN_CYC=10, MAX_CYC=30, NUM_STEPS=5, STEP_W=3, DWELL_FRAMES=2, so STEP_INC=5.
1. Reset release, en=1, mode=01 -> pwm high 10 cycles per 100-cycle frame. step 0,1,2,3,4,0 every 200 cycles. Widths 10,15,20,25,30,10. led toggles each step.
2. mode=10, en=1 for 20 frames -> step sequence 0,1,2,3,4,3,2,1,0,1. Each endpoint held 2 frames only.
3. mode=11 -> step reaches 4 after 8 frames. done=1 and stays with width 30. Switch mode to 01: done=0 the same cycle, step wraps to 0 at the next advance.
4. en=0 mid-frame at step 2 for 10 frames -> step and dwell frozen, pwm 20-cycle pulses continue (macro undefined) or pwm=0 from the next frame (STOP_PULSE_EN). en=1 -> advance to step 3 after 2 more frames.
5. Assert rst_n=0 at frame_cnt=15 with width=20 -> pwm=0 immediately. After release: step=0, done=0, first pulse 10 cycles.
6. mode=00 for 6 frames -> step and width unchanged, led static, frame_tick every 100 cycles.
